if_fetch_stage: RTL and testbench

- Instruction-fetch front end of the 6-stage RISC `processor`, directly upstream of decode.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO so decode back-pressure never drops an instruction.
- Handles control-flow redirects from execute by killing in-flight and buffered fetches.

---
 rtl/rv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/if_fetch_stage.sv | 118 +++++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RISC pipeline front end: data width, the
// canonical NOP encoding, the fetch-buffer entry layout and a PC alignment helper.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  // Force a byte address onto a 32-bit instruction boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous fetch buffer with flush. Push and pop in the same
// cycle are both honoured. Storage is cleared on reset so the head reads as
// zero before the first push.
module fetch_fifo
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // Qualify requests: never pop when empty, never overwrite a full buffer.
  always_comb begin
    do_pop  = pop & (count != 2'd0);
    do_push = push & ((count != 2'd2) | do_pop);
  end

  // Storage, pointers and occupancy; flush discards all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end. Owns the PC, drives a 1-cycle-latency
// instruction memory and buffers returned words in a 2-entry FIFO. Issue is
// credit-limited so buffered plus in-flight words never exceed the FIFO size.
// A redirect flushes the buffer, squashes any in-flight word and restarts
// fetch at the aligned target.
// Optional build macro IF_FETCH_PERF_EN adds saturating stall and redirect
// performance counters.
module if_fetch_stage #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_instr
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  import rv_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag;
  logic            inflight;
  logic            kill;
  logic [1:0]      count;
  logic [2:0]      credit;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Handshake, credit check and memory request, all from current state.
  always_comb begin
    out_valid  = (count != 2'd0) & ~redirect_valid;
    pop        = out_valid & out_ready;
    credit     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue      = ~rst & ~redirect_valid & (credit < 3'(FIFO_DEPTH));
    push       = inflight & ~kill;
    imem_en    = issue;
    imem_addr  = pc;
    push_data  = '{pc: tag, instr: imem_rdata};
    out_pc     = head.pc;
    out_instr  = head.instr;
  end

  // PC, in-flight tracking and squash flag; redirect overrides sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag      <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= align_word(redirect_pc);
      end else if (issue) begin
        pc <= pc + XLEN'(4);
      end else begin
        pc <= pc;
      end
      if (issue) begin
        tag <= pc;
      end else begin
        tag <= tag;
      end
      inflight <= issue;
      kill     <= redirect_valid & inflight;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

`ifdef IF_FETCH_PERF_EN
  // Saturating counters for decode stalls and taken redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt    <= 32'd0;
      perf_redirect_cnt <= 32'd0;
    end else begin
      if (out_valid & ~out_ready & (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (redirect_valid & (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end else begin
        perf_redirect_cnt <= perf_redirect_cnt;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The memory model returns 0x1000+addr
// one cycle after each read strobe. Inputs change 1ns after the rising edge;
// outputs are compared 2ns later, well away from the next edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data = 0x1000 + address, one cycle later.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h0000_1000 + imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #2;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_en",   32'(imem_en),   32'd0);
    check("rst_imem_addr", imem_addr,      32'h0);
    check("rst_out_pc",    out_pc,         32'h0);
    check("rst_out_instr", out_instr,      32'h0);

    // Cycle 0: release reset, first fetch
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("c0_en",   32'(imem_en),   32'd1);
    check("c0_addr", imem_addr,      32'h0);
    check("c0_ov",   32'(out_valid), 32'd0);

    // Cycle 1
    step(1'b1, 1'b0, 32'd0);
    check("c1_en",   32'(imem_en),   32'd1);
    check("c1_addr", imem_addr,      32'h4);
    check("c1_ov",   32'(out_valid), 32'd0);

    // Cycles 2..9: one transfer per cycle, consecutive PCs
    for (int k = 2; k < 10; k++) begin
      step(1'b1, 1'b0, 32'd0);
      check("stream_ov",    32'(out_valid), 32'd1);
      check("stream_pc",    out_pc,         32'(4 * (k - 2)));
      check("stream_instr", out_instr,      32'h1000 + 32'(4 * (k - 2)));
      check("stream_addr",  imem_addr,      32'(4 * k));
    end

    // Cycles 10..14: decode stalls, head stable, no issue
    for (int k = 10; k < 15; k++) begin
      step(1'b0, 1'b0, 32'd0);
      check("stall_en", 32'(imem_en),   32'd0);
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_pc", out_pc,         32'd32);
    end

    // Cycles 15..17: release, no drop or duplicate
    step(1'b1, 1'b0, 32'd0);
    check("rel15_pc",   out_pc,       32'd32);
    check("rel15_en",   32'(imem_en), 32'd1);
    check("rel15_addr", imem_addr,    32'd40);
    step(1'b1, 1'b0, 32'd0);
    check("rel16_pc",   out_pc,    32'd36);
    check("rel16_addr", imem_addr, 32'd44);
    step(1'b1, 1'b0, 32'd0);
    check("rel17_pc",   out_pc,    32'd40);
    check("rel17_addr", imem_addr, 32'd48);

    // Cycle 18: redirect to unaligned 0x203 with entry buffered and word in flight
    step(1'b1, 1'b1, 32'h0000_0203);
    check("rd18_ov", 32'(out_valid), 32'd0);
    check("rd18_en", 32'(imem_en),   32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("rd19_en",   32'(imem_en),   32'd1);
    check("rd19_addr", imem_addr,      32'h200);
    check("rd19_ov",   32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("rd20_ov",   32'(out_valid), 32'd0);
    check("rd20_addr", imem_addr,      32'h204);
    step(1'b1, 1'b0, 32'd0);
    check("rd21_ov",    32'(out_valid), 32'd1);
    check("rd21_pc",    out_pc,         32'h200);
    check("rd21_instr", out_instr,      32'h1200);

    // Cycles 22..23: back-to-back redirects, last wins
    step(1'b1, 1'b1, 32'h0000_0300);
    check("bb22_ov", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 32'h0000_0400);
    check("bb23_en", 32'(imem_en), 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("bb24_en",   32'(imem_en), 32'd1);
    check("bb24_addr", imem_addr,    32'h400);
    step(1'b1, 1'b0, 32'd0);
    check("bb25_ov", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("bb26_ov",    32'(out_valid), 32'd1);
    check("bb26_pc",    out_pc,         32'h400);
    check("bb26_instr", out_instr,      32'h1400);

    // Cycles 27..32: PC wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    check("wr27_ov", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("wr28_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0);
    check("wr29_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'd0);
    check("wr30_pc",    out_pc,    32'hFFFF_FFFC);
    check("wr30_instr", out_instr, 32'h0000_0FFC);
    step(1'b1, 1'b0, 32'd0);
    check("wr31_pc",    out_pc,    32'h0);
    check("wr31_instr", out_instr, 32'h1000);
    step(1'b1, 1'b0, 32'd0);
    check("wr32_pc", out_pc,         32'h4);
    check("wr32_ov", 32'(out_valid), 32'd1);
`ifdef IF_FETCH_PERF_EN
    check("perf_stall",    perf_stall_cnt,    32'd5);
    check("perf_redirect", perf_redirect_cnt, 32'd4);
`endif

    // Mid-cycle asynchronous reset
    rst = 1'b1;
    #1;
    check("arst_ov",   32'(out_valid), 32'd0);
    check("arst_en",   32'(imem_en),   32'd0);
    check("arst_addr", imem_addr,      32'h0);
    check("arst_pc",   out_pc,         32'h0);
`ifdef IF_FETCH_PERF_EN
    check("arst_perf_stall",    perf_stall_cnt,    32'd0);
    check("arst_perf_redirect", perf_redirect_cnt, 32'd0);
`endif

    // Restart from RESET_PC
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rs0_en",   32'(imem_en), 32'd1);
    check("rs0_addr", imem_addr,    32'h0);
    step(1'b1, 1'b0, 32'd0);
    check("rs1_ov", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("rs2_ov",    32'(out_valid), 32'd1);
    check("rs2_pc",    out_pc,         32'h0);
    check("rs2_instr", out_instr,      32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
